// File: rtl/quick_cpu_pkg.sv
// ---------------------------------------------------------------------------
// quick_cpu_pkg
// Shared constants for the quick_cpu 8-bit accumulator machine: geometry,
// opcode values, SYS function codes and the program image loaded at reset.
// No ports (package).
// ---------------------------------------------------------------------------
package quick_cpu_pkg;

  localparam int MEM_DEPTH = 32;   // 5-bit address field limits this to 32
  localparam int ADDR_W    = 5;

  // ins[7:5]
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_SYS = 3'd7;

  // ins[4:0] when op is SYS; any other value is a NOP
  localparam logic [4:0] F_OUT  = 5'd0;
  localparam logic [4:0] F_IN   = 5'd1;
  localparam logic [4:0] F_HALT = 5'd31;

  // Counter program: mem[30] holds the increment, acc counts up and is
  // copied to the output register once per three-instruction loop.
  localparam logic [7:0] DEFAULT_PROG [MEM_DEPTH] = '{
    8'h01, 8'h5E, 8'h00, 8'hE0, 8'h7E, 8'hA3, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/quick_cpu_if.sv
// ---------------------------------------------------------------------------
// quick_cpu interfaces
// quick_cpu_mem_if : core <-> memory bus. Two combinational read ports
//                    (fetch, operand) and one synchronous write port.
//                    master = CPU core, slave = memory.
// quick_cpu_pins_if: the TinyTapeout user pin bundle (ena, ui_in, uo_out,
//                    uio_in, uio_out, uio_oe). master = driver of the chip
//                    inputs, slave = the user macro.
// ---------------------------------------------------------------------------
interface quick_cpu_mem_if;
  logic [4:0] fetch_addr;
  logic [7:0] fetch_data;
  logic [4:0] op_addr;
  logic [7:0] op_data;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output fetch_addr, op_addr, wr_en, wr_addr, wr_data,
    input  fetch_data, op_data
  );
  modport slave (
    input  fetch_addr, op_addr, wr_en, wr_addr, wr_data,
    output fetch_data, op_data
  );
endinterface

interface quick_cpu_pins_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/quick_cpu_mem.sv
// ---------------------------------------------------------------------------
// quick_cpu_mem
// 32x8 register-file memory. Asynchronous active-low reset reloads the
// built-in program image; reads are combinational so the core can fetch
// and fetch an operand in the same cycle.
// Ports:
//   clk   in   clock, write on rising edge
//   rst_n in   asynchronous active-low reset (reload program)
//   bus   slave side of quick_cpu_mem_if
// ---------------------------------------------------------------------------
module quick_cpu_mem
  import quick_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  quick_cpu_mem_if.slave  bus
);

  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= DEFAULT_PROG[i];
      end
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.fetch_data = mem[bus.fetch_addr];
  assign bus.op_data    = mem[bus.op_addr];

endmodule

// File: rtl/quick_cpu.sv
// ---------------------------------------------------------------------------
// quick_cpu
// Single-cycle 8-bit accumulator CPU wrapped in the TinyTapeout user pin set.
// Each rising edge executes mem[pc]; the OUT register drives uo_out.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   ena     in   design-selected flag (ignored)
//   ui_in   in   8  data read by the IN instruction
//   uo_out  out  8  OUT register
//   uio_in  in   8  unused
//   uio_out out  8  debug {halted, 2'b00, pc}
//   uio_oe  out  8  constant 8'hFF
// ---------------------------------------------------------------------------
module quick_cpu
  import quick_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Architectural state keeps its architectural names so it can be probed.
  logic [4:0] pc;
  logic [7:0] acc;
  logic [7:0] out_r;
  logic       halted;

  logic [7:0] w_ins;
  logic [2:0] w_op;
  logic [4:0] w_f;
  logic [7:0] w_opnd;
  logic       w_unused_ok;

  quick_cpu_mem_if w_mem_bus ();

  quick_cpu_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_mem_bus)
  );

  assign w_mem_bus.fetch_addr = pc;
  assign w_mem_bus.op_addr    = w_f;
  assign w_mem_bus.wr_addr    = w_f;
  assign w_mem_bus.wr_data    = acc;
  // A halted core must not keep storing, so the write port is gated too.
  assign w_mem_bus.wr_en      = !halted && (w_op == OP_ST);

  assign w_ins  = w_mem_bus.fetch_data;
  assign w_op   = w_ins[7:5];
  assign w_f    = w_ins[4:0];
  assign w_opnd = w_mem_bus.op_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      acc    <= '0;
      out_r  <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc <= pc + 5'd1;  // 5-bit add wraps 31 -> 0
      case (w_op)
        OP_LDI: acc <= {3'b000, w_f};
        OP_LD:  acc <= w_opnd;
        OP_ST:  ;  // handled by the memory write port
        OP_ADD: acc <= acc + w_opnd;
        OP_SUB: acc <= acc - w_opnd;
        OP_JMP: pc  <= w_f;
        OP_JZ:  if (acc == 8'h00) pc <= w_f;
        default: begin  // OP_SYS
          case (w_f)
            F_OUT:  out_r <= acc;
            F_IN:   acc   <= ui_in;
            F_HALT: begin
              halted <= 1'b1;
              pc     <= pc;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign uo_out  = out_r;
  assign uio_out = {halted, 2'b00, pc};
  assign uio_oe  = 8'hFF;

  assign w_unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_quick_cpu.sv
// ---------------------------------------------------------------------------
// tb_quick_cpu
// Directed bench for quick_cpu. Expected per-edge observations (pc, uo_out,
// uio_out) are queued before each run and popped one per rising edge.
// Custom programs are poked into memory with the clock stopped right after
// a reset pulse, so the first edge after restart executes mem[0].
// ---------------------------------------------------------------------------
module tb_quick_cpu;
  import quick_cpu_pkg::*;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n  = 1'b0;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];

  quick_cpu_pins_if pins ();

  quick_cpu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uo_out  (pins.uo_out),
    .uio_in  (pins.uio_in),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] pc, input logic [7:0] uo,
                      input logic [7:0] uio);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    e.uo  = uo;
    e.uio = uio;
    sb.push_back(e);
  endtask

  // Default counter program: pc 1..5 then cycles 3,4,5; OUT at edges 4,7,10...
  task automatic push_default(input string tag, input int n);
    int p;
    int u;
    for (int e = 1; e <= n; e++) begin
      p = (e <= 5) ? e : 3 + ((e - 6) % 3);
      u = (e < 4) ? 0 : (e - 4) / 3;
      push($sformatf("%s_e%0d", tag, e), 8'(p), 8'(u), 8'(p));
    end
  endtask

  task automatic drain();
    exp_t e;
    edge_no = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk);
      #1;
      edge_no++;
      check8({e.tag, "/pc"},  {3'b000, dut.pc}, e.pc);
      check8({e.tag, "/uo"},  pins.uo_out,      e.uo);
      check8({e.tag, "/uio"}, pins.uio_out,     e.uio);
      check8({e.tag, "/oe"},  pins.uio_oe,      8'hFF);
      $display("edge %0d %s pc=%0d uo_out=%02h uio_out=%02h", edge_no, e.tag,
               dut.pc, pins.uo_out, pins.uio_out);
    end
  endtask

  // Stop the clock high, pulse reset, confirm reset state, leave it released.
  task automatic halt_clock_and_reset(input string tag);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check8({tag, "/rst_uo"},  pins.uo_out,  8'h00);
    check8({tag, "/rst_uio"}, pins.uio_out, 8'h00);
    check8({tag, "/rst_oe"},  pins.uio_oe,  8'hFF);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic poke(input int addr, input logic [7:0] data);
    dut.u_mem.mem[addr] = data;
  endtask

  initial begin
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;

    // Reset state while rst_n is held low
    #2;
    check8("reset/pc",  {3'b000, dut.pc}, 8'h00);
    check8("reset/uo",  pins.uo_out,      8'h00);
    check8("reset/uio", pins.uio_out,     8'h00);
    check8("reset/oe",  pins.uio_oe,      8'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: default counter program, 20 edges
    push_default("default", 20);
    drain();

    // 2: asynchronous reset mid-run (uo_out is 5 here), then restart
    rst_n = 1'b0;
    #1;
    check8("midrst/uo",  pins.uo_out,      8'h00);
    check8("midrst/pc",  {3'b000, dut.pc}, 8'h00);
    check8("midrst/uio", pins.uio_out,     8'h00);
    check8("midrst/oe",  pins.uio_oe,      8'hFF);
    @(posedge clk);
    #1;
    check8("midrst_hold/pc", {3'b000, dut.pc}, 8'h00);
    check8("midrst_hold/uo", pins.uo_out,      8'h00);
    rst_n = 1'b1;
    push_default("restart", 12);
    drain();

    // 3: IN / OUT / HALT
    halt_clock_and_reset("p3");
    poke(0, 8'hE1);
    poke(1, 8'hE0);
    poke(2, 8'hFF);
    pins.ui_in = 8'hA5;
    clk_en = 1'b1;
    push("inout_e1", 8'd1, 8'h00, 8'h01);
    push("inout_e2", 8'd2, 8'hA5, 8'h02);
    push("halt_e3",  8'd2, 8'hA5, 8'h82);
    drain();
    pins.ui_in = 8'h3C;
    push("halt_e4",  8'd2, 8'hA5, 8'h82);
    push("halt_e5",  8'd2, 8'hA5, 8'h82);
    drain();

    // 4a: LDI 5; ST 20; SUB 20; JZ 7 -> taken
    halt_clock_and_reset("p4a");
    poke(0, 8'h05);
    poke(1, 8'h54);
    poke(2, 8'h94);
    poke(3, 8'hC7);
    poke(7, 8'hFF);
    clk_en = 1'b1;
    push("jz_taken_e1", 8'd1, 8'h00, 8'h01);
    push("jz_taken_e2", 8'd2, 8'h00, 8'h02);
    push("jz_taken_e3", 8'd3, 8'h00, 8'h03);
    push("jz_taken_e4", 8'd7, 8'h00, 8'h07);
    push("jz_taken_e5", 8'd7, 8'h00, 8'h87);
    drain();

    // 4b: LDI 5; ST 20; LDI 3; JZ 7 -> not taken, falls to HALT at 4
    halt_clock_and_reset("p4b");
    poke(0, 8'h05);
    poke(1, 8'h54);
    poke(2, 8'h03);
    poke(3, 8'hC7);
    poke(4, 8'hFF);
    clk_en = 1'b1;
    push("jz_fall_e1", 8'd1, 8'h00, 8'h01);
    push("jz_fall_e2", 8'd2, 8'h00, 8'h02);
    push("jz_fall_e3", 8'd3, 8'h00, 8'h03);
    push("jz_fall_e4", 8'd4, 8'h00, 8'h04);
    push("jz_fall_e5", 8'd4, 8'h00, 8'h84);
    drain();

    // 5: LD 20 (FF); OUT; ADD 21 (+1 wraps to 0); OUT; JZ 7 -> taken
    halt_clock_and_reset("p5");
    poke(0, 8'h34);
    poke(1, 8'hE0);
    poke(2, 8'h75);
    poke(3, 8'hE0);
    poke(4, 8'hC7);
    poke(7, 8'hFF);
    poke(20, 8'hFF);
    poke(21, 8'h01);
    clk_en = 1'b1;
    push("ovf_e1", 8'd1, 8'h00, 8'h01);
    push("ovf_e2", 8'd2, 8'hFF, 8'h02);
    push("ovf_e3", 8'd3, 8'hFF, 8'h03);
    push("ovf_e4", 8'd4, 8'h00, 8'h04);
    push("ovf_e5", 8'd7, 8'h00, 8'h07);
    push("ovf_e6", 8'd7, 8'h00, 8'h87);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
